pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RISC-V pipeline (Fetch, Decode, Execute, Memory, Writeback).
- Resolves RAW hazards by forwarding into Execute.
- Inserts load-use bubbles, flushes on taken branches, and freezes the pipeline while data memory is not ready.
- Keeps saturating stall and flush counters for performance debug; sits beside the stage registers and drives their stall and flush controls.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/forward_unit.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: controller state encoding, forwarding-select codes and the x0
// register index, shared by the hazard controller and its forwarding units.
package pipeline_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational forwarding select for one ALU operand
//
// Purpose: picks the ALU operand source for the Execute-stage instruction.
// Ports:
//   enable_i       forwarding active (controller out of INIT)
//   rs_e_i         source register of the Execute instruction
//   reg_write_m_i  Memory stage writes the register file
//   rd_m_i         Memory stage destination register
//   reg_write_w_i  Writeback stage writes the register file
//   rd_w_i         Writeback destination register
//   fwd_sel_o      FWD_MEM / FWD_WB / FWD_RF
module forward_unit
    import pipeline_pkg::*;
(
    input  logic       enable_i,
    input  logic [4:0] rs_e_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_w_i,
    input  logic [4:0] rd_w_i,
    output logic [1:0] fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (enable_i) begin
            // The Memory stage holds the younger result, so it is checked first.
            if (reg_write_m_i && (rd_m_i != REG_X0) && (rd_m_i == rs_e_i)) begin
                fwd_sel_o = FWD_MEM;
            end else if (reg_write_w_i && (rd_w_i != REG_X0) && (rd_w_i == rs_e_i)) begin
                fwd_sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard and sequencing controller for a 5-stage pipeline
//
// Purpose: forwarding selects, load-use bubbles, branch flushes, data-memory
// freeze with timeout, and saturating stall/flush performance counters.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   RS1_D, RS2_D                    Decode source registers
//   RS1_E, RS2_E, RD_E, ResultSrcE  Execute sources, destination, load flag
//   PCSrcE                          branch taken in Execute
//   RegWriteM, RD_M                 Memory stage write-back info
//   RegWriteW, RDW                  Writeback stage write-back info
//   MemReqM, MemReadyM              data-memory request / completion
//   StallF/D/E/M, FlushD/E/W        stage register controls
//   ForwardAE, ForwardBE            ALU operand selects
//   mem_err                         sticky memory-timeout flag
//   stall_cnt, flush_cnt            saturating performance counters
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteW,
    input  logic [4:0]       RDW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              fwd_en;
    logic              load_use;
    logic              stall_inc, flush_inc;

    assign fwd_en   = (state_q != INIT);
    assign load_use = ResultSrcE && (RD_E != REG_X0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

    forward_unit u_fwd_a (
        .enable_i      (fwd_en),
        .rs_e_i        (RS1_E),
        .reg_write_m_i (RegWriteM),
        .rd_m_i        (RD_M),
        .reg_write_w_i (RegWriteW),
        .rd_w_i        (RDW),
        .fwd_sel_o     (ForwardAE)
    );

    forward_unit u_fwd_b (
        .enable_i      (fwd_en),
        .rs_e_i        (RS2_E),
        .reg_write_m_i (RegWriteM),
        .rd_m_i        (RD_M),
        .reg_write_w_i (RegWriteW),
        .rd_w_i        (RDW),
        .fwd_sel_o     (ForwardBE)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        unique case (state_q)
            INIT: begin
                // Hold the PC and clear the downstream stages for one cycle.
                StallF  = 1'b1;
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                FlushW  = 1'b1;
                wait_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    // Freeze takes effect immediately; this cycle is the first
                    // of the wait, so the counter starts at one.
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    StallM  = 1'b1;
                    FlushW  = 1'b1;
                    wait_d  = WAIT_W'(1);
                    state_d = MEM_WAIT;
                end else if (PCSrcE) begin
                    // A taken branch kills the dependent instruction, so no bubble.
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    wait_d  = '0;
                    state_d = RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        // Give up on the access rather than deadlock the core.
                        mem_err_d = 1'b1;
                        wait_d    = '0;
                        state_d   = RUN;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = INIT;
                wait_d  = '0;
            end
        endcase
    end

    assign stall_inc = StallF && (state_q != INIT);
    assign flush_inc = FlushE && (state_q != INIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= INIT;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RDW;
    logic          ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RD_M(RD_M), .RegWriteW(RegWriteW), .RDW(RDW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic drive_idle();
        RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RDW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first RUN cycle with counters cleared.
    task automatic apply_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        next_cycle();
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                           input logic ww, input logic [4:0] rdw);
        if (wm && rdm != 0 && rdm == rs) return 2'b10;
        if (ww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_reset();
        logic [10:0] ctl;
        rst = 1'b0;
        drive_idle();
        RegWriteM = 1; RD_M = 3; RS1_E = 3;
        next_cycle();
        @(negedge clk);
        ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
        checks++;
        if (ctl !== 11'b1000_111_00_00) begin
            failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 11'b1000_111_00_00);
        end
        checks++;
        if ({mem_err, stall_cnt, flush_cnt} !== '0) begin
            failures++; $display("FAIL reset_regs got=%b/%0d/%0d exp=0/0/0", mem_err, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
        checks++;
        if (ctl !== 11'b1000_111_00_00) begin
            failures++; $display("FAIL init_after_release got=%b exp=%b", ctl, 11'b1000_111_00_00);
        end
        next_cycle();
        @(negedge clk);
        ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
        checks++;
        if (ctl !== 11'b0000_000_10_00) begin
            failures++; $display("FAIL run_after_init got=%b exp=%b", ctl, 11'b0000_000_10_00);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mem_err, stall_cnt, flush_cnt} !== '0) begin
            failures++; $display("FAIL init_not_counted got=%b/%0d/%0d exp=0/0/0", mem_err, stall_cnt, flush_cnt);
        end
    endtask

    typedef struct packed {
        logic       wm;
        logic [4:0] rdm;
        logic       ww;
        logic [4:0] rdw;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } fwd_case_t;

    task automatic test_forwarding();
        fwd_case_t cases [7];
        cases[0] = '{1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0, 2'b10, 2'b00};
        cases[1] = '{1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0, 2'b01, 2'b00};
        cases[2] = '{1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
        cases[3] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
        cases[4] = '{1'b1, 5'd5, 1'b1, 5'd7, 5'd7, 5'd5, 2'b01, 2'b10};
        cases[5] = '{1'b0, 5'd5, 1'b0, 5'd7, 5'd7, 5'd5, 2'b00, 2'b00};
        cases[6] = '{1'b1, 5'd9, 1'b1, 5'd9, 5'd1, 5'd9, 2'b00, 2'b10};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            RegWriteM = cases[i].wm; RD_M = cases[i].rdm;
            RegWriteW = cases[i].ww; RDW  = cases[i].rdw;
            RS1_E = cases[i].rs1; RS2_E = cases[i].rs2;
            @(negedge clk);
            checks++;
            if ({ForwardAE, ForwardBE} !== {cases[i].exp_a, cases[i].exp_b}) begin
                failures++;
                $display("FAIL fwd_case%0d got=%b_%b exp=%b_%b", i, ForwardAE, ForwardBE, cases[i].exp_a, cases[i].exp_b);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_load_use();
        apply_reset();
        ResultSrcE = 1; RD_E = 6; RS1_D = 1; RS2_D = 6;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100) begin
            failures++; $display("FAIL lu_bubble got=%b exp=%b", {StallF, StallD, FlushE, StallE, FlushD}, 5'b11100);
        end
        next_cycle();
        ResultSrcE = 0;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            failures++; $display("FAIL lu_one_bubble got=%b exp=000", {StallF, StallD, FlushE});
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== {CW'(1), CW'(1)}) begin
            failures++; $display("FAIL lu_counts got=%0d/%0d exp=1/1", stall_cnt, flush_cnt);
        end
        next_cycle();
        ResultSrcE = 1; RD_E = 0; RS1_D = 0; RS2_D = 0;
        @(negedge clk);
        checks++;
        if ({StallF, FlushE} !== 2'b00) begin
            failures++; $display("FAIL lu_x0 got=%b exp=00", {StallF, FlushE});
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_branch_wins();
        apply_reset();
        ResultSrcE = 1; RD_E = 6; RS2_D = 6; PCSrcE = 1;
        @(negedge clk);
        checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
            failures++; $display("FAIL branch_lu got=%b exp=1100", {FlushD, FlushE, StallF, StallD});
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if ({stall_cnt, flush_cnt} !== {CW'(0), CW'(1)}) begin
            failures++; $display("FAIL branch_counts got=%0d/%0d exp=0/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] ctl;
        apply_reset();
        MemReqM = 1; MemReadyM = 0;
        ResultSrcE = 1; RD_E = 4; RS1_D = 4; PCSrcE = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ctl = {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE};
            checks++;
            if (ctl !== 7'b1111100) begin
                failures++; $display("FAIL mem_freeze%0d got=%b exp=1111100", k, ctl);
            end
            next_cycle();
        end
        MemReadyM = 1; PCSrcE = 0;
        @(negedge clk);
        ctl = {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE};
        checks++;
        if (ctl !== 7'b0000000) begin
            failures++; $display("FAIL mem_release got=%b exp=0000000", ctl);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if ({mem_err, stall_cnt, flush_cnt} !== {1'b0, CW'(3), CW'(0)}) begin
            failures++; $display("FAIL mem_counts got=%b/%0d/%0d exp=0/3/0", mem_err, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int k = 0; k < MT; k++) begin
            @(negedge clk);
            checks++;
            if ({StallF, StallM, FlushW, mem_err} !== 4'b1110) begin
                failures++; $display("FAIL tmo_freeze%0d got=%b exp=1110", k, {StallF, StallM, FlushW, mem_err});
            end
            next_cycle();
        end
        MemReqM = 0;
        @(negedge clk);
        checks++;
        if ({StallF, StallM, FlushW, mem_err} !== 4'b0001) begin
            failures++; $display("FAIL tmo_release got=%b exp=0001", {StallF, StallM, FlushW, mem_err});
        end
        checks++;
        if (stall_cnt !== CW'(MT)) begin
            failures++; $display("FAIL tmo_stall_cnt got=%0d exp=%0d", stall_cnt, MT);
        end
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b1) begin
            failures++; $display("FAIL tmo_sticky got=%b exp=1", mem_err);
        end
        rst = 0;
        next_cycle();
        rst = 1;
        @(negedge clk);
        checks++;
        if ({mem_err, stall_cnt} !== {1'b0, CW'(0)}) begin
            failures++; $display("FAIL tmo_cleared got=%b/%0d exp=0/0", mem_err, stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        MemReqM = 1; MemReadyM = 0;
        repeat (2) next_cycle();
        rst = 0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({StallF, StallE, StallM, FlushD, FlushE, FlushW, stall_cnt} !== {6'b100111, CW'(0)}) begin
            failures++;
            $display("FAIL rst_in_wait got=%b/%0d exp=100111/0", {StallF, StallE, StallM, FlushD, FlushE, FlushW}, stall_cnt);
        end
        rst = 1;
        drive_idle();
        repeat (2) next_cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        ResultSrcE = 1; RD_E = 2; RS1_D = 2;
        repeat (CMAX) next_cycle();
        @(negedge clk);
        checks++;
        if ({stall_cnt, flush_cnt} !== {CW'(CMAX), CW'(CMAX)}) begin
            failures++; $display("FAIL sat_reach got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, CMAX, CMAX);
        end
        repeat (5) next_cycle();
        @(negedge clk);
        checks++;
        if ({stall_cnt, flush_cnt} !== {CW'(CMAX), CW'(CMAX)}) begin
            failures++; $display("FAIL sat_hold got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, CMAX, CMAX);
        end
        drive_idle();
    endtask

    // Model: phase 0 = draining after reset, 1 = running, 2 = waiting on memory.
    // 'frozen' counts freeze cycles already spent in the current memory wait.
    task automatic test_random();
        int          phase = 1;
        int          frozen = 0;
        logic        err = 0;
        int          sc = 0;
        int          fc = 0;
        logic        lu, freeze;
        logic [6:0]  ectl;
        logic [21:0] exp_v, got_v;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
            RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
            RD_E = 5'($urandom_range(0, 3)); RD_M = 5'($urandom_range(0, 3)); RDW = 5'($urandom_range(0, 3));
            ResultSrcE = 1'($urandom); PCSrcE = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemReqM = ($urandom_range(0, 3) == 0); MemReadyM = 1'($urandom);
            @(negedge clk);
            lu = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
            freeze = (phase == 1 && MemReqM && !MemReadyM) || (phase == 2 && !MemReadyM);
            if (phase == 0)       ectl = 7'b1000_111;
            else if (freeze)      ectl = 7'b1111_001;
            else if (phase == 2)  ectl = 7'b0000_000;
            else if (PCSrcE)      ectl = 7'b0000_110;
            else if (lu)          ectl = 7'b1100_010;
            else                  ectl = 7'b0000_000;
            exp_v = {ectl,
                     (phase == 0) ? 2'b00 : ref_fwd(RS1_E, RegWriteM, RD_M, RegWriteW, RDW),
                     (phase == 0) ? 2'b00 : ref_fwd(RS2_E, RegWriteM, RD_M, RegWriteW, RDW),
                     err, CW'(sc), CW'(fc)};
            got_v = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                     ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt};
            checks++;
            if (got_v !== exp_v) begin
                failures++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got_v, exp_v);
            end
            if (!rst) begin
                phase = 0; frozen = 0; err = 0; sc = 0; fc = 0;
            end else begin
                if (phase != 0 && ectl[6] && sc < CMAX) sc++;
                if (phase != 0 && ectl[1] && fc < CMAX) fc++;
                if (phase == 0) begin
                    phase = 1;
                end else if (phase == 1) begin
                    if (freeze) begin phase = 2; frozen = 1; end
                end else if (MemReadyM) begin
                    phase = 1; frozen = 0;
                end else if (frozen + 1 == MT) begin
                    phase = 1; frozen = 0; err = 1;
                end else begin
                    frozen++;
                end
            end
            next_cycle();
        end
        rst = 1;
        drive_idle();
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_wins();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
